// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the run-of-ones tracker.
// Detector benches reuse these through the tracker.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int               RUN_W   = 3;
    localparam logic [RUN_W-1:0] RUN_MAX = 3'd7;

endpackage

// File: rtl/seq_pattern_tx_ones_run.sv
// Saturating count of consecutive 1s on a valid-qualified serial stream.
// The count includes the current bit; any invalid or zero bit breaks the run.
module ones_run_tracker
    import seq_pattern_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             x_valid,
    input  logic             x_out,
    output logic [RUN_W-1:0] ones_run
);

    logic [RUN_W-1:0] run_prev;

    // NOTE: assign a default before any branch so always_comb never infers a latch.
    always_comb begin
        ones_run = '0;
        if (x_valid && x_out) begin
            ones_run = (run_prev == RUN_MAX) ? RUN_MAX : run_prev + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_prev <= '0;
        end else begin
            run_prev <= ones_run;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Shifts a captured word out MSB-first, repeated reps times with GAP idle
// cycles between repetitions, and reports the running count of 1s.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data,
    input  logic [CNTW-1:0]  reps,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] ones_run
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
    logic [CNTW-1:0]  repleft;
    logic [GAP_W-1:0] gapcnt;
    logic             done_r;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            word    <= '0;
            shreg   <= '0;
            bitcnt  <= '0;
            repleft <= '0;
            gapcnt  <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && reps != '0) begin
                        word    <= data;
                        shreg   <= data;
                        repleft <= reps;
                        bitcnt  <= BIT_W'(WIDTH - 1);
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt - BIT_W'(1);
                        if (bitcnt == '0) begin
                            if (repleft == CNTW'(1)) begin
                                state  <= ST_IDLE;
                                done_r <= 1'b1;
                            end else begin
                                repleft <= repleft - CNTW'(1);
                                if (GAP == 0) begin
                                    shreg  <= word;
                                    bitcnt <= BIT_W'(WIDTH - 1);
                                end else begin
                                    gapcnt <= GAP_W'(GAP - 1);
                                    state  <= ST_GAP;
                                end
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (gapcnt == '0) begin
                        shreg  <= word;
                        bitcnt <= BIT_W'(WIDTH - 1);
                        state  <= ST_SEND;
                    end else begin
                        gapcnt <= gapcnt - GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign x_valid = (state == ST_SEND);
    assign x_out   = x_valid & shreg[WIDTH-1];
    assign busy    = (state != ST_IDLE);
    assign done    = done_r;

    ones_run_tracker u_run (
        .clk      (clk),
        .rstn     (rstn),
        .x_valid  (x_valid),
        .x_out    (x_out),
        .ones_run (ones_run)
    );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=2, one with GAP=0.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_a, start_b, abort;
    logic [7:0] data;
    logic [3:0] reps;

    logic       x_out_a, x_valid_a, busy_a, done_a;
    logic       x_out_b, x_valid_b, busy_b, done_b;
    logic [2:0] ones_run_a, ones_run_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(8), .GAP(2), .CNTW(4)) dut (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort),
        .data(data), .reps(reps),
        .x_out(x_out_a), .x_valid(x_valid_a), .busy(busy_a), .done(done_a),
        .ones_run(ones_run_a)
    );

    seq_pattern_tx #(.WIDTH(8), .GAP(0), .CNTW(4)) dut0 (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort),
        .data(data), .reps(reps),
        .x_out(x_out_b), .x_valid(x_valid_b), .busy(busy_b), .done(done_b),
        .ones_run(ones_run_b)
    );

    // Per-cycle expectations are MSB-first bit masks: cycle i is bit 31-i,
    // cycle 0 being the first cycle after the accepting edge.
    typedef struct {
        logic [7:0]  data;
        logic [3:0]  reps;
        bit          sel;       // 0: GAP=2 instance, 1: GAP=0 instance
        int          poke;      // cycle of a spurious start, -1 for none
        int          abort_at;  // cycle abort is held high, -1 for none
        int          exp_busy;
        bit          exp_done;
        logic [31:0] exp_x;
        logic [31:0] exp_v;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input bit sel, input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   run;
        logic ex, ev, eb, s_x, s_v, s_b, s_d;
        logic [2:0] s_r;
        run = 0;
        @(negedge clk);
        data = v.data;
        reps = v.reps;
        drive_start(v.sel, 1'b1);
        for (int i = 0; i <= v.exp_busy + 3; i++) begin
            @(negedge clk);
            s_x = v.sel ? x_out_b    : x_out_a;
            s_v = v.sel ? x_valid_b  : x_valid_a;
            s_b = v.sel ? busy_b     : busy_a;
            s_d = v.sel ? done_b     : done_a;
            s_r = v.sel ? ones_run_b : ones_run_a;
            ex  = (i < 32) ? v.exp_x[31-i] : 1'b0;
            ev  = (i < 32) ? v.exp_v[31-i] : 1'b0;
            eb  = (i < v.exp_busy);
            run = (ex && ev) ? ((run == 7) ? 7 : run + 1) : 0;
            check($sformatf("v%0d c%0d busy", idx, i), 32'(s_b), 32'(eb));
            check($sformatf("v%0d c%0d x_valid", idx, i), 32'(s_v), 32'(ev));
            check($sformatf("v%0d c%0d x_out", idx, i), 32'(s_x), 32'(ex));
            check($sformatf("v%0d c%0d ones_run", idx, i), 32'(s_r), 32'(run));
            check($sformatf("v%0d c%0d done", idx, i), 32'(s_d),
                  32'((i == v.exp_busy) && v.exp_done));
            drive_start(v.sel, 1'b0);
            abort = (i == v.abort_at);
            if (i == v.poke) begin
                drive_start(v.sel, 1'b1);
                data = 8'hFF;
                reps = 4'd5;
            end
        end
        drive_start(v.sel, 1'b0);
        abort = 1'b0;
    endtask

    initial begin
        int exp_run76[8];
        exp_run76 = '{0, 1, 2, 3, 0, 1, 2, 0};

        //            data   reps  sel  poke abrt busy done  exp_x          exp_v
        tbl[0] = '{8'h76, 4'd1, 1'b0, -1, -1,  8, 1'b1, 32'h7600_0000, 32'hFF00_0000};
        tbl[1] = '{8'hA5, 4'd2, 1'b0, -1, -1, 18, 1'b1, 32'hA529_4000, 32'hFF3F_C000};
        tbl[2] = '{8'hFF, 4'd2, 1'b1, -1, -1, 16, 1'b1, 32'hFFFF_0000, 32'hFFFF_0000};
        tbl[3] = '{8'h80, 4'd3, 1'b0, -1, -1, 28, 1'b1, 32'h8020_0800, 32'hFF3F_CFF0};
        tbl[4] = '{8'h01, 4'd2, 1'b1, -1, -1, 16, 1'b1, 32'h0101_0000, 32'hFFFF_0000};
        tbl[5] = '{8'h76, 4'd0, 1'b0, -1, -1,  0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[6] = '{8'h76, 4'd1, 1'b0,  3, -1,  8, 1'b1, 32'h7600_0000, 32'hFF00_0000};
        tbl[7] = '{8'hA5, 4'd3, 1'b0, -1,  4,  5, 1'b0, 32'hA000_0000, 32'hF800_0000};
        tbl[8] = '{8'h76, 4'd1, 1'b0, -1,  7,  8, 1'b0, 32'h7600_0000, 32'hFF00_0000};
        tbl[9] = '{8'hA5, 4'd2, 1'b0, -1,  8,  9, 1'b0, 32'hA500_0000, 32'hFF00_0000};

        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        data = '0; reps = '0;
        #12;
        check("reset busy",     32'(busy_a | busy_b), 0);
        check("reset x_valid",  32'(x_valid_a | x_valid_b), 0);
        check("reset x_out",    32'(x_out_a | x_out_b), 0);
        check("reset done",     32'(done_a | done_b), 0);
        check("reset ones_run", 32'(ones_run_a | ones_run_b), 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(k, tbl[k]);

        // Exact run sequence for 0111_0110.
        @(negedge clk);
        data = 8'h76; reps = 4'd1; start_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("run76 c%0d", i), 32'(ones_run_a), 32'(exp_run76[i]));
        end
        repeat (3) @(negedge clk);

        // Saturation on the back-to-back instance.
        data = 8'hFF; reps = 4'd2; start_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            check($sformatf("sat c%0d", i), 32'(ones_run_b), 32'((i < 7) ? i + 1 : 7));
        end
        repeat (3) @(negedge clk);

        // Start accepted in the done cycle.
        data = 8'h76; reps = 4'd1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b done",  32'(done_a), 1);
        check("b2b idle",  32'(busy_a), 0);
        data = 8'hA5; reps = 4'd1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("b2b busy",    32'(busy_a), 1);
        check("b2b x_valid", 32'(x_valid_a), 1);
        check("b2b x_out",   32'(x_out_a), 1);
        check("b2b no done", 32'(done_a), 0);
        repeat (8) @(negedge clk);
        check("b2b done2", 32'(done_a), 1);
        repeat (2) @(negedge clk);

        // Asynchronous reset while in the gap.
        data = 8'hA5; reps = 4'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        check("pre-rst busy",    32'(busy_a), 1);
        check("pre-rst x_valid", 32'(x_valid_a), 0);
        #2 rstn = 1'b0;
        #1;
        check("arst busy",     32'(busy_a), 0);
        check("arst x_valid",  32'(x_valid_a), 0);
        check("arst x_out",    32'(x_out_a), 0);
        check("arst done",     32'(done_a), 0);
        check("arst ones_run", 32'(ones_run_a), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_vec(100, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that produces the one-bit `x` stimulus stream consumed by the team's Mealy/Moore sequence detectors. A `WIDTH`-bit word is shifted out MSB-first, repeated a programmable number of times, with optional zero-filled gap cycles between repetitions. A saturating run-of-ones count accompanies the stream, so benches can compute the expected detector output alongside it.

## Interface
- `WIDTH`, 8: pattern word width in bits; must be at least 2.
- `GAP`, 2: idle cycles (`x_out=0`, `x_valid=0`) inserted between repetitions; 0 means back-to-back words.
- `CNTW`, 4: width of the repetition count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request transmission; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of an active transmission.
- `data`  in  WIDTH  pattern word, captured on the accepted `start`.
- `reps`  in  CNTW  number of word repetitions, captured on the accepted `start`.
- `x_out`  out  1  serial bit; 0 whenever `x_valid=0`.
- `x_valid`  out  1  high during cycles carrying a pattern bit.
- `busy`  out  1  high in SEND and GAP.
- `done`  out  1  one-cycle pulse after the final bit of the final repetition.
- `ones_run`  out  3  consecutive 1s emitted, including the current bit; saturates at 7.

## Operation
- States are IDLE, SEND and GAP. Reset enters IDLE.
- Registers:
  - `word`: captured pattern.
  - `shreg`: shift register.
  - `bitcnt`: bits left in the word.
  - `repleft`: repetitions remaining.
  - `gapcnt`: gap cycles remaining.
  - `run_prev`: 3-bit run count.
  - `done_r`.
- IDLE:
  - If `start=1` and `reps!=0`: `word<=data`, `shreg<=data`, `repleft<=reps`, `bitcnt<=WIDTH-1`, next state SEND.
  - If `start=1` and `reps=0`: ignored; no `busy`, no `done`.
- SEND:
  - `x_out=shreg[WIDTH-1]`, `x_valid=1`, `busy=1`.
  - Each cycle shifts `shreg` left by one and decrements `bitcnt`.
- Last bit of a word (`bitcnt=0`):
  - If `repleft=1`: next state IDLE and `done_r<=1`.
  - Else if `GAP=0`: `repleft` decrements, `shreg<=word`, `bitcnt<=WIDTH-1`, stay in SEND.
  - Else: `repleft` decrements, `gapcnt<=GAP-1`, next state GAP.
- GAP:
  - `x_out=0`, `x_valid=0`, `busy=1`.
  - When `gapcnt=0`: reload `shreg<=word`, `bitcnt<=WIDTH-1`, next state SEND. Otherwise decrement `gapcnt`.
- `abort=1` in SEND or GAP: next state IDLE with no `done`. `abort` is ignored in IDLE.
- `start` is ignored while `busy=1`.
- `done=done_r`; `done_r` clears after one cycle.
- `start` is accepted in the cycle `done=1`, because the block is already in IDLE.
- `ones_run`:
  - When `x_valid&x_out`: `ones_run = min(run_prev+1, 7)`; otherwise `ones_run = 0`.
  - `run_prev<=ones_run` every cycle, so gap and idle cycles break a run.

## Timing
- Reset values: state IDLE, `x_out=0`, `x_valid=0`, `busy=0`, `done=0`, `ones_run=0`, all counters 0. `rstn` low mid-transmission forces these values immediately, without waiting for a clock edge.
- `start` accepted at edge k: the first bit (`data[WIDTH-1]`) is valid in the cycle following edge k.
- Busy duration is `reps*WIDTH + (reps-1)*GAP` cycles. `done` is high in the first cycle after busy ends, with `busy=0`.
- `x_out`, `x_valid` and `busy` are decoded from registered state only, with no input-to-output combinational path. `ones_run` is combinational from registered `x_out` and `run_prev`.
- Simultaneous `abort` and last bit: `abort` wins; no `done`.

## Structure
- Shared package holds:
  - the state encoding `ST_IDLE=2'b00`, `ST_SEND=2'b01`, `ST_GAP=2'b10`;
  - `RUN_W=3` and `RUN_MAX=7`.
- One natural sub-module: `ones_run_tracker`, the saturating run counter taking `x_valid` and `x_out` and producing `ones_run`. It is reused by detector benches.
- Top level contains the FSM, shift register and counters.

## Test plan
- Single word: `data=8'b0111_0110`, `reps=1`, `GAP=2`.
  - Required: `x_out` = 0,1,1,1,0,1,1,0 and `ones_run` = 0,1,2,3,0,1,2,0.
  - Required: `busy` high for 8 cycles, then `done` pulses once.
- Repeat with gap: `data=8'hA5`, `reps=2`, `GAP=2`.
  - Required: 8 valid bits 1,0,1,0,0,1,0,1, then 2 cycles `x_valid=0`, `x_out=0`, then the same 8 bits.
  - Required: `busy` high for 18 cycles; `done` one cycle.
- Saturation: `data=8'hFF`, `reps=2`, `GAP=0`.
  - Required: 16 consecutive 1s; `ones_run` = 1..7, then 7 for the remainder; `busy` high for 16 cycles.
- Rejects: `start` with `reps=0`; `start` pulsed mid-word.
  - Required: `reps=0` start leaves `busy=0` and `done=0`; the mid-word start leaves the stream and busy length unchanged.
- Abort and back-to-back:
  - `abort` at bit 4 of `reps=3`: `busy=0` the next cycle and `done` never asserts.
  - `start` asserted in the `done` cycle: the new first bit appears in the next cycle.
- Reset mid-run: drop `rstn` during GAP.
  - Required: all outputs 0 without waiting for a clock edge. After release, a new `start` transmits from bit `WIDTH-1`.
